// File: rtl/axi4_lite_read_slave_pkg.sv
// Shared AXI4-Lite definitions: response codes and the read-responder state set.
// Used by the read slave, the existing read master and future write blocks.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCAL_REQ,
    ST_RESP
  } s_axi_read_states;

endpackage

// File: rtl/axi4_lite_read_slave_if.sv
// AXI4-Lite read channel plus the local req/ack read port seen by the read slave.
// The slave modport is the responder view; master is the requester/memory view.
interface axi4_lite_read_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  logic                  mem_rd_req;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_rd_ack;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_rd_err;

  modport slave (
    input  S_AXI_ARADDR,
    input  S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA,
    output S_AXI_RRESP,
    output S_AXI_RVALID,
    input  S_AXI_RREADY,
    output mem_rd_req,
    output mem_rd_addr,
    input  mem_rd_ack,
    input  mem_rd_data,
    input  mem_rd_err
  );

  modport master (
    output S_AXI_ARADDR,
    output S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA,
    input  S_AXI_RRESP,
    input  S_AXI_RVALID,
    output S_AXI_RREADY,
    input  mem_rd_req,
    input  mem_rd_addr,
    output mem_rd_ack,
    output mem_rd_data,
    output mem_rd_err
  );

endinterface

// File: rtl/axi4_lite_read_slave.sv
// AXI4-Lite read responder: decodes one AR at a time against an address window,
// forwards in-window reads to a local req/ack port and answers with DECERR/SLVERR/OKAY.
module axi4_lite_read_slave
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_RANGE     = 32'h0000_1000,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axi4_lite_read_slave_if.slave  bus
);

  localparam int BYTE_LSB = $clog2(DATA_WIDTH / 8);
  localparam int CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("DATA_WIDTH must be 32 or 64");
  end
  if ((ADDR_RANGE & (ADDR_RANGE - 1'b1)) != '0) begin : g_bad_range
    $error("ADDR_RANGE must be a power of two");
  end
  if ((BASE_ADDR & (ADDR_RANGE - 1'b1)) != '0) begin : g_bad_base
    $error("BASE_ADDR must be aligned to ADDR_RANGE");
  end

  s_axi_read_states      state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  arready_reg, arready_next;
  logic                  rvalid_reg, rvalid_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic [1:0]            rresp_reg, rresp_next;
  logic                  req_reg, req_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;

  // Decode in ADDR_WIDTH+1 bits so a window touching the top of the map cannot wrap.
  logic [ADDR_WIDTH:0]   addr_ext;
  logic [ADDR_WIDTH:0]   base_ext;
  logic [ADDR_WIDTH:0]   limit_ext;
  logic                  in_window;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] offset_aligned;

  assign addr_ext  = {1'b0, bus.S_AXI_ARADDR};
  assign base_ext  = {1'b0, BASE_ADDR};
  assign limit_ext = base_ext + {1'b0, ADDR_RANGE};
  assign in_window = (addr_ext >= base_ext) && (addr_ext < limit_ext);
  assign offset    = bus.S_AXI_ARADDR - BASE_ADDR;

  // Sub-word address bits are dropped; misaligned requests read the containing word.
  for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_align
    if (gi < BYTE_LSB) begin : g_lo
      assign offset_aligned[gi] = 1'b0;
    end else begin : g_hi
      assign offset_aligned[gi] = offset[gi];
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    arready_next  = arready_reg;
    rvalid_next   = rvalid_reg;
    rdata_next    = rdata_reg;
    rresp_next    = rresp_reg;
    req_next      = req_reg;
    mem_addr_next = mem_addr_reg;

    case (state_reg)
      ST_IDLE: begin
        arready_next = 1'b1;
        if (bus.S_AXI_ARVALID && arready_reg) begin
          arready_next = 1'b0;
          if (in_window) begin
            state_next    = ST_LOCAL_REQ;
            req_next      = 1'b1;
            mem_addr_next = offset_aligned;
            cnt_next      = '0;
          end else begin
            state_next  = ST_RESP;
            rvalid_next = 1'b1;
            rdata_next  = '0;
            rresp_next  = RESP_DECERR;
          end
        end
      end

      ST_LOCAL_REQ: begin
        // An ack on the final watchdog cycle still delivers its data.
        if (bus.mem_rd_ack) begin
          state_next  = ST_RESP;
          req_next    = 1'b0;
          cnt_next    = '0;
          rvalid_next = 1'b1;
          rdata_next  = bus.mem_rd_data;
          rresp_next  = bus.mem_rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (cnt_reg == CNT_LAST) begin
          state_next  = ST_RESP;
          req_next    = 1'b0;
          cnt_next    = '0;
          rvalid_next = 1'b1;
          rdata_next  = '0;
          rresp_next  = RESP_SLVERR;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (bus.S_AXI_RREADY) begin
          state_next   = ST_IDLE;
          rvalid_next  = 1'b0;
          arready_next = 1'b1;
        end
      end

      default: begin
        state_next   = ST_IDLE;
        arready_next = 1'b0;
        rvalid_next  = 1'b0;
        req_next     = 1'b0;
        cnt_next     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
      rresp_reg    <= RESP_OKAY;
      req_reg      <= 1'b0;
      mem_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      arready_reg  <= arready_next;
      rvalid_reg   <= rvalid_next;
      rdata_reg    <= rdata_next;
      rresp_reg    <= rresp_next;
      req_reg      <= req_next;
      mem_addr_reg <= mem_addr_next;
    end
  end

  assign bus.S_AXI_ARREADY = arready_reg;
  assign bus.S_AXI_RVALID  = rvalid_reg;
  assign bus.S_AXI_RDATA   = rdata_reg;
  assign bus.S_AXI_RRESP   = rresp_reg;
  assign bus.mem_rd_req    = req_reg;
  assign bus.mem_rd_addr   = mem_addr_reg;

endmodule

// File: tb/tb_axi4_lite_read_slave.sv
// Directed plus randomized bench for the AXI4-Lite read responder; expected
// responses come from a window/latency model of the read rules.
module tb_axi4_lite_read_slave;

  localparam int          AW      = 32;
  localparam int          DW      = 32;
  localparam logic [31:0] BASE    = 32'h4000_0000;
  localparam logic [31:0] RANGE   = 32'h0000_1000;
  localparam int          TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   overlap_cnt = 0;

  always #5 clk = ~clk;

  axi4_lite_read_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_read_slave #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .BASE_ADDR     (BASE),
    .ADDR_RANGE    (RANGE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always @(negedge clk) begin
    if (rst_n && bus.mem_rd_req && bus.S_AXI_RVALID) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arready"}, 64'(bus.S_AXI_ARREADY), 64'd0);
    check({tag, "_rvalid"},  64'(bus.S_AXI_RVALID),  64'd0);
    check({tag, "_rdata"},   64'(bus.S_AXI_RDATA),   64'd0);
    check({tag, "_rresp"},   64'(bus.S_AXI_RRESP),   64'd0);
    check({tag, "_req"},     64'(bus.mem_rd_req),    64'd0);
    check({tag, "_memaddr"}, 64'(bus.mem_rd_addr),   64'd0);
  endtask

  // One AR/R transaction. ack_cyc counts cycles after the AR handshake (req first
  // seen at 1); values above TIMEOUT mean the local side never answers.
  task automatic do_read(input logic [31:0] addr, input int ack_cyc, input logic [31:0] data,
                         input logic err, input int rr_wait, input logic chain,
                         input logic [31:0] next_addr);
    logic [63:0] a64;
    logic        in_win;
    logic [31:0] exp_off;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          end_cyc;
    int          waited;
    logic        held_ok;
    logic        resp_ok;

    a64     = 64'(addr);
    in_win  = (a64 >= 64'(BASE)) && (a64 < 64'(BASE) + 64'(RANGE));
    exp_off = (addr - BASE) & ~32'h3;
    if (!in_win) begin
      end_cyc = 0; exp_data = 32'h0; exp_resp = 2'b11;
    end else if (ack_cyc <= TIMEOUT) begin
      end_cyc = ack_cyc; exp_data = data; exp_resp = err ? 2'b10 : 2'b00;
    end else begin
      end_cyc = TIMEOUT; exp_data = 32'h0; exp_resp = 2'b10;
    end

    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    waited = 0;
    while (!bus.S_AXI_ARREADY && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("ar_accept", 64'(bus.S_AXI_ARREADY), 64'd1);
    if (!bus.S_AXI_ARREADY) begin
      bus.S_AXI_ARVALID = 1'b0;
      return;
    end

    @(negedge clk);
    if (chain) bus.S_AXI_ARADDR = next_addr;
    else       bus.S_AXI_ARVALID = 1'b0;

    if (in_win) begin
      check("req_rise", 64'(bus.mem_rd_req), 64'd1);
      check("mem_addr", 64'(bus.mem_rd_addr), 64'(exp_off));
      held_ok = 1'b1;
      for (int c = 1; c <= end_cyc; c++) begin
        if (!bus.mem_rd_req || bus.S_AXI_RVALID || bus.S_AXI_ARREADY ||
            bus.mem_rd_addr !== exp_off) held_ok = 1'b0;
        bus.mem_rd_ack  = (c == ack_cyc);
        bus.mem_rd_data = (c == ack_cyc) ? data : $urandom;
        bus.mem_rd_err  = (c == ack_cyc) ? err : 1'($urandom);
        @(negedge clk);
      end
      bus.mem_rd_ack = 1'b0;
      check("req_held", 64'(held_ok), 64'd1);
    end else begin
      check("no_local_req", 64'(bus.mem_rd_req), 64'd0);
    end

    check("rvalid", 64'(bus.S_AXI_RVALID), 64'd1);
    check("req_drop", 64'(bus.mem_rd_req), 64'd0);
    check("rdata", 64'(bus.S_AXI_RDATA), 64'(exp_data));
    check("rresp", 64'(bus.S_AXI_RRESP), 64'(exp_resp));

    resp_ok = 1'b1;
    for (int w = 0; w < rr_wait; w++) begin
      bus.S_AXI_RREADY = 1'b0;
      bus.mem_rd_ack   = 1'($urandom);
      bus.mem_rd_data  = $urandom;
      bus.mem_rd_err   = 1'($urandom);
      @(negedge clk);
      if (!bus.S_AXI_RVALID || bus.S_AXI_RDATA !== exp_data ||
          bus.S_AXI_RRESP !== exp_resp || bus.S_AXI_ARREADY || bus.mem_rd_req)
        resp_ok = 1'b0;
    end
    check("resp_stable", 64'(resp_ok), 64'd1);

    bus.mem_rd_ack   = 1'b0;
    bus.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_RREADY = 1'b0;
    check("rvalid_drop", 64'(bus.S_AXI_RVALID), 64'd0);
    check("arready_back", 64'(bus.S_AXI_ARREADY), 64'd1);
    $display("read addr=%08h resp=%0d data=%08h end_cyc=%0d", addr, exp_resp, exp_data, end_cyc);
  endtask

  initial begin
    logic [31:0] ra;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;
    bus.mem_rd_ack    = 1'b0;
    bus.mem_rd_data   = '0;
    bus.mem_rd_err    = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);
    check("por_arready_rise", 64'(bus.S_AXI_ARREADY), 64'd1);

    // Basic, decode error, local error under backpressure, timeout, ack on last cycle
    do_read(32'h4000_0010, 3, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 32'h0);
    do_read(32'h4000_1000, 1, 32'h5555_5555, 1'b0, 0, 1'b0, 32'h0);
    do_read(32'h4000_0FFC, 2, 32'h1234_5678, 1'b1, 5, 1'b0, 32'h0);
    do_read(32'h4000_0004, 100, 32'hAAAA_AAAA, 1'b0, 0, 1'b0, 32'h0);
    do_read(32'h4000_0004, TIMEOUT, 32'hCAFE_F00D, 1'b0, 0, 1'b0, 32'h0);
    do_read(32'h3FFF_FFFF, 1, 32'h1, 1'b0, 1, 1'b0, 32'h0);
    do_read(32'hFFFF_FFFF, 1, 32'h1, 1'b0, 0, 1'b0, 32'h0);
    do_read(32'h4000_0000, 1, 32'h0BAD_CAFE, 1'b0, 0, 1'b0, 32'h0);

    // Reset while the local read is pending
    bus.S_AXI_ARADDR  = 32'h4000_0040;
    bus.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_req", 64'(bus.mem_rd_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_local");
    @(negedge clk);
    check("rst_arready_hold", 64'(bus.S_AXI_ARREADY), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_arready_rise", 64'(bus.S_AXI_ARREADY), 64'd1);

    // Reset while a response is waiting for RREADY
    bus.S_AXI_ARADDR  = 32'h4000_2000;
    bus.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    check("pre_rst_rvalid", 64'(bus.S_AXI_RVALID), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_resp");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst2_arready_rise", 64'(bus.S_AXI_ARREADY), 64'd1);
    do_read(32'h4000_0020, 2, 32'h0F0F_0F0F, 1'b0, 0, 1'b0, 32'h0);

    // Back-to-back with ARVALID held high, second address misaligned
    do_read(32'h4000_0100, 2, 32'h1111_2222, 1'b0, 2, 1'b1, 32'h4000_0003);
    do_read(32'h4000_0003, 1, 32'h3333_4444, 1'b0, 0, 1'b0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: ra = BASE + $urandom_range(0, 32'hFFF);
        3:       ra = BASE - $urandom_range(1, 16);
        4:       ra = BASE + RANGE + $urandom_range(0, 16);
        default: ra = $urandom;
      endcase
      do_read(ra, int'($urandom_range(1, 20)), $urandom, 1'($urandom),
              int'($urandom_range(0, 3)), 1'b0, 32'h0);
    end

    check("no_req_rvalid_overlap", 64'(overlap_cnt), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi4_lite_read_slave.md
Name: axi4_lite_read_slave

Overview:
AXI4-Lite read-channel responder that sits in front of a memory-mapped peripheral or memory in the SoC. It accepts one AR transaction at a time and decodes it against a configured address window. In-window reads go to a simple local req/ack read port; out-of-window reads are answered directly with an error. It returns RDATA/RRESP and holds them stable until RREADY, with a watchdog that converts a hung local read into SLVERR.

Parameters:
ADDR_WIDTH, 32, AXI address width in bits
DATA_WIDTH, 32, AXI/local data width in bits (32 or 64)
BASE_ADDR, 32'h0000_0000, byte address of window start; must be aligned to ADDR_RANGE
ADDR_RANGE, 32'h0000_1000, window size in bytes; power of two
TIMEOUT_CYCLES, 16, maximum LOCAL_REQ cycles before SLVERR; must be >= 2

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  slave ready to accept address
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  master ready for data
mem_rd_req  out  1  local read request, level, held until ack
mem_rd_addr  out  ADDR_WIDTH  word-aligned byte offset into window
mem_rd_ack  in  1  local read complete; data and err valid this cycle
mem_rd_data  in  DATA_WIDTH  local read data
mem_rd_err  in  1  local read error, qualified by ack

Behaviour:
- Reset (rst_n low, any state, mid-transaction included): state IDLE; ARREADY=0, RVALID=0, RDATA=0, RRESP=OKAY, mem_rd_req=0, mem_rd_addr=0, timeout counter=0. Any in-flight transaction is dropped.
- All outputs are registered.
- ARREADY is 1 only in IDLE. It rises on the first clk edge after rst_n deasserts. Only one transaction is outstanding.
- IDLE: on ARVALID&&ARREADY, latch ARADDR and drop ARREADY.
  - In window, i.e. BASE_ADDR <= addr < BASE_ADDR+ADDR_RANGE: go to LOCAL_REQ. mem_rd_addr = (addr-BASE_ADDR) with the low log2(DATA_WIDTH/8) bits forced to 0. mem_rd_req=1 from the next cycle.
  - Out of window: go to RESP with RDATA=0, RRESP=DECERR (2'b11). The local port is not touched.
- LOCAL_REQ: mem_rd_req and mem_rd_addr are held stable; the counter increments each cycle.
  - On mem_rd_ack: latch data. RRESP=SLVERR (2'b10) if mem_rd_err, else OKAY (2'b00). Drop req and go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack: RDATA=0, RRESP=SLVERR, drop req, go to RESP.
  - Ack in the same cycle as timeout: ack wins.
  - Counter clears on leaving LOCAL_REQ.
- RESP: RVALID=1. RDATA and RRESP are stable until RVALID&&RREADY. Then RVALID drops, go to IDLE, ARREADY=1 the next cycle.
- mem_rd_ack outside LOCAL_REQ is ignored.
- Latency: AR handshake at cycle 0, req at 1, ack at cycle k → RVALID at k+1. DECERR reaches RVALID at cycle 1.
- ARADDR misalignment is ignored; there is no error for sub-word addresses.
- Address compare uses full ADDR_WIDTH unsigned arithmetic; no wrap past the top of the address space.

Decomposition:
- axi4_lite_pkg holds: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11, and the typedef enum s_axi_read_states {ST_IDLE, ST_LOCAL_REQ, ST_RESP}. The package is shared with the existing read master and future write blocks.
- No sub-module. Address decode and the timeout counter are inline.

Test Plan:
Parameters for all scenarios: BASE_ADDR=0x4000_0000, ADDR_RANGE=0x1000, TIMEOUT_CYCLES=16.
1. Basic read: ARADDR=0x4000_0010, local acks 2 cycles after req with data 0xDEAD_BEEF, RREADY=1 → mem_rd_addr=0x010; RVALID one cycle after ack; RDATA=0xDEAD_BEEF, RRESP=00; ARREADY back to 1 the next cycle.
2. Decode error: ARADDR=0x4000_1000 → mem_rd_req never asserts; RVALID at cycle 1 with RDATA=0, RRESP=11.
3. Backpressure plus local error: ARADDR=0x4000_0FFC, ack with err=1 and data 0x1234_5678, RREADY held low 5 cycles → RVALID, RDATA=0x1234_5678, RRESP=10 stable for all 5 cycles; ARREADY stays 0; completes on RREADY.
4. Timeout: ARADDR=0x4000_0004 with no ack → req drops after 16 cycles; RVALID with RRESP=10, RDATA=0. Variant with ack on exactly the 16th cycle → RRESP=00 with ack data.
5. Reset mid-operation: assert rst_n=0 during LOCAL_REQ, then during RESP → all outputs at reset values immediately; ARREADY=0 during reset, 1 one edge after release; a subsequent read to 0x4000_0020 completes normally.
6. Back-to-back and misaligned: two reads, the second with ARADDR=0x4000_0003, ARVALID held continuously → second AR accepted only after the first R handshake; mem_rd_addr=0x000; no overlap of RVALID with mem_rd_req.
